// File: rtl/bip_debug_pkg.sv
// -----------------------------------------------------------------------------
// bip_debug_pkg
//   Shared definitions for the bip UART run controller: command byte codes,
//   controller state encoding, status-report geometry and the report byte
//   selector used by the report mux.
// -----------------------------------------------------------------------------
package bip_debug_pkg;

    // Command bytes accepted from the UART RX FIFO
    localparam logic [7:0]  CMD_RUN  = 8'h52;   // 'R' run until halt or cycle limit
    localparam logic [7:0]  CMD_STEP = 8'h53;   // 'S' one enabled CPU cycle
    localparam logic [7:0]  CMD_CLR  = 8'h43;   // 'C' CPU reset pulse, counter cleared

    // Cycle counter saturation value
    localparam logic [15:0] MAX_CYC  = 16'hFFFF;

    // Status report: 6 bytes, index 0..5
    localparam int          REPORT_LEN = 6;
    localparam logic [2:0]  LAST_IDX   = 3'd5;

    // Controller states (3-bit encoding)
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_STEP = 3'd2,
        ST_CLR  = 3'd3,
        ST_SEND = 3'd4
    } state_e;

    // Select one byte of the report. All three words are already 16 bits wide.
    function automatic logic [7:0] report_byte(
        input logic [15:0] cycles,
        input logic [15:0] acc16,
        input logic [15:0] pc16,
        input logic [2:0]  idx
    );
        logic [7:0] result;
        case (idx)
            3'd0:    result = cycles[15:8];
            3'd1:    result = cycles[7:0];
            3'd2:    result = acc16[15:8];
            3'd3:    result = acc16[7:0];
            3'd4:    result = pc16[15:8];
            3'd5:    result = pc16[7:0];
            default: result = 8'h00;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/bip_debug_report.sv
// -----------------------------------------------------------------------------
// bip_debug_report
//   6:1 byte multiplexer that turns {cycles, acc, pc} into the status report
//   byte addressed by idx_i. acc and pc are zero-extended to 16 bits.
// Ports
//   cycles_i  in  16      enabled-cycle counter
//   acc_i     in  DATA_W  CPU accumulator
//   pc_i      in  PC_W    CPU program counter
//   idx_i     in  3       report byte index (0..5)
//   byte_o    out 8       selected report byte (0 for indices outside 0..5)
// -----------------------------------------------------------------------------
module bip_debug_report
    import bip_debug_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int PC_W   = 11
) (
    input  logic [15:0]       cycles_i,
    input  logic [DATA_W-1:0] acc_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [2:0]        idx_i,
    output logic [7:0]        byte_o
);

    logic [15:0] acc_ext_s;
    logic [15:0] pc_ext_s;

    // Widen the CPU words to the fixed 16-bit report fields
    assign acc_ext_s = 16'(acc_i);
    assign pc_ext_s  = 16'(pc_i);

    // Byte selection
    always_comb begin
        byte_o = report_byte(cycles_i, acc_ext_s, pc_ext_s, idx_i);
    end

endmodule

// File: rtl/bip_debug_ctrl.sv
// -----------------------------------------------------------------------------
// bip_debug_ctrl
//   UART-driven run controller for the bip CPU. Pops command bytes from the
//   UART RX FIFO, gates the CPU (run-to-halt, single step, clear), counts the
//   enabled CPU cycles and, after every command, pushes a 6-byte status report
//   {cycles, acc, pc} into the UART TX FIFO.
// Ports
//   clk       in   1       system clock
//   reset     in   1       asynchronous active-low reset
//   rx_empty  in   1       RX FIFO empty
//   r_data    in   8       RX FIFO head byte
//   rd_uart   out  1       RX pop strobe
//   tx_full   in   1       TX FIFO full
//   w_data    out  8       TX byte, valid with wr_uart (0 otherwise)
//   wr_uart   out  1       TX push strobe
//   halt      in   1       CPU is decoding HLT this cycle
//   acc       in   DATA_W  CPU accumulator
//   pc        in   PC_W    CPU program counter
//   cpu_en    out  1       CPU advance enable
//   cpu_rst   out  1       synchronous CPU reset pulse, active-high
//   busy      out  1       controller is not in IDLE
// -----------------------------------------------------------------------------
module bip_debug_ctrl
    import bip_debug_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int PC_W   = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_empty,
    input  logic [7:0]        r_data,
    output logic              rd_uart,
    input  logic              tx_full,
    output logic [7:0]        w_data,
    output logic              wr_uart,
    input  logic              halt,
    input  logic [DATA_W-1:0] acc,
    input  logic [PC_W-1:0]   pc,
    output logic              cpu_en,
    output logic              cpu_rst,
    output logic              busy
);

    state_e      state_q;
    state_e      state_d;
    logic [15:0] cycles_q;
    logic [15:0] cycles_d;
    logic [2:0]  idx_q;
    logic [2:0]  idx_d;
    logic        at_limit_s;
    logic        may_advance_s;
    logic [7:0]  report_byte_s;

    assign at_limit_s    = (cycles_q == MAX_CYC);
    // The CPU may only advance when it is not halted and the counter has room
    assign may_advance_s = (halt == 1'b0) && (at_limit_s == 1'b0);

    // Report byte for the current index; acc/pc are sampled live because
    // the CPU is frozen for the whole SEND phase.
    bip_debug_report #(
        .DATA_W (DATA_W),
        .PC_W   (PC_W)
    ) u_report (
        .cycles_i (cycles_q),
        .acc_i    (acc),
        .pc_i     (pc),
        .idx_i    (idx_q),
        .byte_o   (report_byte_s)
    );

    // State, cycle counter and report index registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cycles_q <= 16'h0000;
            idx_q    <= 3'd0;
        end else begin
            state_q  <= state_d;
            cycles_q <= cycles_d;
            idx_q    <= idx_d;
        end
    end

    // Next-state logic and strobes
    always_comb begin
        state_d  = state_q;
        cycles_d = cycles_q;
        idx_d    = idx_q;
        rd_uart  = 1'b0;
        wr_uart  = 1'b0;
        cpu_en   = 1'b0;
        cpu_rst  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Gating with reset keeps the pop strobe low while reset is
                // asserted, even though the FIFO may already hold bytes.
                if ((rx_empty == 1'b0) && (reset == 1'b1)) begin
                    rd_uart = 1'b1;
                    case (r_data)
                        CMD_RUN:  state_d = ST_RUN;
                        CMD_STEP: state_d = ST_STEP;
                        CMD_CLR:  state_d = ST_CLR;
                        default:  state_d = ST_IDLE;   // unknown byte: drop it
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                if (may_advance_s) begin
                    cpu_en   = 1'b1;
                    cycles_d = cycles_q + 16'd1;
                    state_d  = ST_RUN;
                end else begin
                    state_d  = ST_SEND;
                end
            end

            ST_STEP: begin
                if (may_advance_s) begin
                    cpu_en   = 1'b1;
                    cycles_d = cycles_q + 16'd1;
                end else begin
                    cycles_d = cycles_q;
                end
                state_d = ST_SEND;
            end

            ST_CLR: begin
                cpu_rst  = 1'b1;
                cycles_d = 16'h0000;
                state_d  = ST_SEND;
            end

            ST_SEND: begin
                // Never push into a full FIFO; the index simply waits.
                if (tx_full == 1'b0) begin
                    wr_uart = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = 3'd0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ST_SEND;
                    end
                end else begin
                    idx_d   = idx_q;
                    state_d = ST_SEND;
                end
            end

            default: begin
                // Illegal encoding: recover to a clean idle state
                idx_d   = 3'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Data and status outputs
    always_comb begin
        if (wr_uart == 1'b1) begin
            w_data = report_byte_s;
        end else begin
            w_data = 8'h00;
        end
        busy = (state_q != ST_IDLE);
    end

endmodule
